grant_arbiter: RTL and testbench
================================

GRANT_ARBITER -- requirements
Module: grant_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, sets the maximum cycles a grant is held before forced revoke; legal range 2..255, used only under GRANT_TIMEOUT_EN.
REQ-002 clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  8  request lines; bit i is requester i.
REQ-005 release  input  1  one-cycle pulse from the current grantee ending its tenure.
REQ-006 grant_valid  output  1  high while a grant is active.
REQ-007 grant_code  output  3  binary index of the current grantee.
REQ-008 grant  output  8  one-hot grant; equals decode(grant_code) when grant_valid=1, else 8'b0.
REQ-009 timeout  output  1  one-cycle pulse on forced revoke; constant 0 when GRANT_TIMEOUT_EN is undefined.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-011 IDLE with req==0 SHALL stay in IDLE, with grant_valid=0 and grant=0.
REQ-012 IDLE with req!=0 at edge n SHALL load grant_code with the winner, set grant_valid=1 and go to BUSY; the grant is visible after edge n (1-cycle latency).
REQ-013 Winner selection: first set bit of req when searching indices (last+1), (last+2), ... mod 8, where last is the index of the most recent grant; the search wraps from 7 to 0.
REQ-014 last SHALL update to the winner on every new grant.
REQ-015 In BUSY, grant_code and grant SHALL stay stable; changes on other req bits are ignored.
REQ-016 In BUSY, release=1 or req[grant_code]=0 SHALL end the grant: after the next edge, grant_valid=0 and the state is IDLE.
REQ-017 There is one mandatory IDLE cycle between grants, so the earliest regrant comes two edges after release.
REQ-018 release asserted in IDLE SHALL be ignored.
REQ-019 grant_code SHALL hold its last value while grant_valid=0.
REQ-020 When only the previous grantee requests, it SHALL be re-granted, because the search wraps back to it.

Reset
REQ-021 With reset=1 at an edge: state=IDLE, grant_valid=0, grant=0, grant_code=0, timeout=0, hold counter=0, last=7, so requester 0 has first priority.
REQ-022 Reset SHALL override every other input, including mid-BUSY; the grant drops on the same edge and no timeout pulse is produced.

Configuration
REQ-023 Macro GRANT_TIMEOUT_EN defined: an 8-bit hold counter clears on grant and increments each BUSY cycle.
REQ-024 With GRANT_TIMEOUT_EN, a grant that reaches MAX_HOLD BUSY cycles without release SHALL be revoked (go to IDLE) and timeout SHALL pulse for one cycle coincident with grant_valid falling.
REQ-025 With GRANT_TIMEOUT_EN, release or req drop in the same cycle as expiry SHALL count as a normal release, with timeout=0.
REQ-026 GRANT_TIMEOUT_EN undefined: no counter logic, timeout tied 0, and grants are unbounded.

Structure
REQ-027 Package arb_pkg SHALL hold N_REQ=8, CODE_W=3, the state enum {IDLE, BUSY} and the reset value of last (7).
REQ-028 The one-hot output SHALL come from a sub-module code_decoder (3-bit code plus enable in, 8-bit one-hot out, all zeros when enable=0), driven by grant_code and grant_valid.
REQ-029 The block SHALL have no other sub-modules, and the winner-select logic SHALL be combinational inside grant_arbiter.

Verification
REQ-030 Reset, then req=8'h01 -> next edge: grant_valid=1, grant_code=0, grant=8'h01.
REQ-031 req=8'hFF held, release pulsed after each grant -> grant_code sequence 0,1,2,...,7,0, each grant separated by one IDLE cycle.
REQ-032 Grantee 5 active, req=8'h24, release -> next grant goes to 2, confirming wrap from index 6 past 7 to 2.
REQ-033 Grantee 3 drops req[3] with no release -> grant_valid=0 after the next edge; an interleaved release in IDLE has no effect.
REQ-034 Reset asserted mid-BUSY with grant_code=4 -> next edge: all outputs zero, then req=8'h11 grants 0.
REQ-035 GRANT_TIMEOUT_EN, MAX_HOLD=4, grant held with no release -> revoke after 4 BUSY cycles with a single timeout pulse; the same test without the macro -> no revoke, timeout stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the grant arbiter: requester count, code width,
// FSM state encoding and the post-reset value of the round-robin pointer.
package arb_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Pointer starts at the top index so the first search begins at requester 0.
    localparam logic [CODE_W-1:0] LAST_RST = CODE_W'(N_REQ - 1);

endpackage

// File: rtl/code_decoder.sv
// Binary-to-one-hot decoder with enable; output is all zeros while disabled.
import arb_pkg::*;

module code_decoder (
    input  logic [CODE_W-1:0] code,
    input  logic              en,
    output logic [N_REQ-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[code] = 1'b1;
    end

endmodule

// File: rtl/grant_arbiter.sv
// Round-robin grant arbiter: 8 requesters, one grant at a time, one IDLE cycle
// between grants. GRANT_TIMEOUT_EN adds a MAX_HOLD-cycle forced revoke.
// The release pulse is named release_req because "release" is a reserved word.
import arb_pkg::*;

module grant_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req,
    input  logic              release_req,
    output logic              grant_valid,
    output logic [CODE_W-1:0] grant_code,
    output logic [N_REQ-1:0]  grant,
    output logic              timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("grant_arbiter: MAX_HOLD must be in 2..255");
    end

    state_t            state, state_n;
    logic [CODE_W-1:0] last, last_n;
    logic [CODE_W-1:0] code_n;
    logic [CODE_W-1:0] win, idx;
    logic              end_normal;
    logic              expire;

    // Lowest offset from last+1 wins; offset N_REQ wraps back to last itself.
    always_comb begin
        win = last;
        idx = last;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = last + CODE_W'(i);
            if (req[idx]) win = idx;
        end
    end

    assign end_normal = release_req || !req[grant_code];

    always_comb begin
        state_n = state;
        code_n  = grant_code;
        last_n  = last;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = BUSY;
                    code_n  = win;
                    last_n  = win;
                end
            end
            BUSY: begin
                if (end_normal || expire) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant_code <= '0;
            last       <= LAST_RST;
        end else begin
            state      <= state_n;
            grant_code <= code_n;
            last       <= last_n;
        end
    end

`ifdef GRANT_TIMEOUT_EN
    logic [7:0] hold_cnt;

    assign expire = (state == BUSY) && (hold_cnt == 8'(MAX_HOLD - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state == IDLE && |req) hold_cnt <= '0;
            else if (state == BUSY)    hold_cnt <= hold_cnt + 8'd1;
            // A normal release in the expiry cycle takes precedence over revoke.
            timeout <= expire && !end_normal;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign grant_valid = (state == BUSY);

    code_decoder u_dec (
        .code   (grant_code),
        .en     (grant_valid),
        .onehot (grant)
    );

endmodule

// File: tb/tb_grant_arbiter.sv
// Directed bench for grant_arbiter: vector table plus round-robin and hold-timeout sequences.
module tb_grant_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       release_req;
    logic       grant_valid;
    logic [2:0] grant_code;
    logic [7:0] grant;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    grant_arbiter #(.MAX_HOLD(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .release_req (release_req),
        .grant_valid (grant_valid),
        .grant_code  (grant_code),
        .grant       (grant),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [7:0] rq;
        logic       rel;
        logic       v;
        logic [2:0] code;
        logic [7:0] g;
        logic       tmo;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string nm, input logic v, input logic [2:0] code,
                         input logic [7:0] g, input logic tmo);
        n_cmp++;
        if (grant_valid !== v || grant_code !== code || grant !== g || timeout !== tmo) begin
            n_bad++;
            $display("FAIL %s: got v=%b code=%0d grant=%h tmo=%b, want v=%b code=%0d grant=%h tmo=%b",
                     nm, grant_valid, grant_code, grant, timeout, v, code, g, tmo);
        end
    endtask

    task automatic tick(input logic rst, input logic [7:0] rq, input logic rel);
        reset = rst; req = rq; release_req = rel;
        @(posedge clock); #1;
    endtask

    task automatic add(input logic rst, input logic [7:0] rq, input logic rel,
                       input logic v, input logic [2:0] code, input logic [7:0] g);
        vec_t e;
        e.rst = rst; e.rq = rq; e.rel = rel; e.v = v; e.code = code; e.g = g; e.tmo = 1'b0;
        tv.push_back(e);
    endtask

    logic tmo_en;
    logic exp_v, exp_t;

    initial begin
`ifdef GRANT_TIMEOUT_EN
        tmo_en = 1'b1;
`else
        tmo_en = 1'b0;
`endif
        reset = 1'b1; req = '0; release_req = 1'b0;

        //  rst  req    rel   v  code grant
        add(1, 8'h00, 0,    0, 0, 8'h00);  // reset state
        add(0, 8'h00, 0,    0, 0, 8'h00);  // idle, no req
        add(0, 8'h01, 0,    1, 0, 8'h01);  // first grant to 0
        add(0, 8'h01, 0,    1, 0, 8'h01);
        add(0, 8'h03, 0,    1, 0, 8'h01);  // other req ignored while busy
        add(0, 8'h03, 1,    0, 0, 8'h00);  // release, code holds
        add(0, 8'h03, 0,    1, 1, 8'h02);  // rr moves to 1
        add(0, 8'h02, 0,    1, 1, 8'h02);
        add(0, 8'h00, 0,    0, 1, 8'h00);  // grantee drops req
        add(0, 8'h00, 1,    0, 1, 8'h00);  // release in idle ignored
        add(0, 8'h08, 0,    1, 3, 8'h08);
        add(0, 8'h00, 0,    0, 3, 8'h00);  // req[3] drop, no release
        add(0, 8'h00, 1,    0, 3, 8'h00);
        add(0, 8'h20, 0,    1, 5, 8'h20);
        add(0, 8'h24, 1,    0, 5, 8'h00);
        add(0, 8'h24, 0,    1, 2, 8'h04);  // wrap 6,7,0,1 -> 2
        add(0, 8'h04, 1,    0, 2, 8'h00);
        add(0, 8'h10, 0,    1, 4, 8'h10);
        add(1, 8'h10, 0,    0, 0, 8'h00);  // reset mid-busy
        add(0, 8'h11, 0,    1, 0, 8'h01);  // last=7 -> 0 first
        add(0, 8'h11, 1,    0, 0, 8'h00);
        add(0, 8'h01, 0,    1, 0, 8'h01);  // sole previous grantee re-granted
        add(0, 8'h00, 0,    0, 0, 8'h00);

        foreach (tv[k]) begin
            tick(tv[k].rst, tv[k].rq, tv[k].rel);
            check($sformatf("vec%0d", k), tv[k].v, tv[k].code, tv[k].g, tv[k].tmo);
        end

        // Full round-robin with req=FF and a release after every grant.
        tick(1, 8'h00, 0);
        for (int k = 0; k <= 8; k++) begin
            tick(0, 8'hFF, 0);
            check($sformatf("rr_grant%0d", k), 1, 3'(k % 8), 8'(1 << (k % 8)), 0);
            tick(0, 8'hFF, 1);
            check($sformatf("rr_idle%0d", k), 0, 3'(k % 8), 8'h00, 0);
        end

        // Hold with no release: revoke after 4 busy cycles only when enabled.
        tick(1, 8'h00, 0);
        for (int e = 1; e <= 6; e++) begin
            tick(0, 8'h02, 0);
            exp_v = !(tmo_en && e == 5);
            exp_t = tmo_en && e == 5;
            check($sformatf("hold_e%0d", e), exp_v, 1, exp_v ? 8'h02 : 8'h00, exp_t);
        end
        // Release in the expiry cycle is a normal release with no timeout.
        for (int e = 7; e <= 9; e++) begin
            tick(0, 8'h02, 0);
            check($sformatf("hold_e%0d", e), 1, 1, 8'h02, 0);
        end
        tick(0, 8'h02, 1);
        check("hold_rel_at_expiry", 0, 1, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
